svd_result_unloader: RTL
========================

// Module: svd_result_unloader
// PURPOSE
//  Output stage directly downstream of svd8x4. On the rising edge of en_out_svd, captures the
//  three 16-element result words (A, U, V). Then streams them one element per handshake over a
//  valid/ready port: A[0..15], then U[0..15], then V[0..15]. Decouples the SVD core from a
//  slower consumer (host bus or result FIFO).
// PARAMETERS
//  DATA_WIDTH   24                       width of one matrix element (matches svd8x4 data_width)
//  NUM_ELEM     16                       elements packed per result word
//  DATA_CORDIC  NUM_ELEM*DATA_WIDTH      width of each packed result word (384)
// PORTS
//  clk          in   1            single clock, rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  en_out_svd   in   1            result-valid level from svd8x4; its rising edge triggers a capture
//  data_in_A    in   DATA_CORDIC  packed A result; element k at [k*DATA_WIDTH +: DATA_WIDTH]
//  data_in_U    in   DATA_CORDIC  packed U result, same packing
//  data_in_V    in   DATA_CORDIC  packed V result, same packing
//  out_ready    in   1            consumer accepts the current element
//  clr_overrun  in   1            synchronous clear of the overrun flag
//  out_valid    out  1            out_data/out_sel/out_idx/out_last are valid
//  out_data     out  DATA_WIDTH   current element
//  out_sel      out  2            matrix tag: 0=A, 1=U, 2=V (3 never driven)
//  out_idx      out  4            element index within the matrix, 0..15
//  out_last     out  1            high on V[15] only
//  busy         out  1            high in STREAM state
//  overrun      out  1            sticky: a new result arrived while busy
// BEHAVIOUR
//  - Reset: every output and internal register goes to 0; state=IDLE; shadow registers=0.
//    Reset mid-stream aborts the stream; no element is replayed after reset.
//  - Edge detect: en_q <= en_out_svd; rise = en_out_svd & ~en_q.
//  - IDLE: on rise, latch data_in_A/U/V into shadow registers, set sel=0 and idx=0, go to STREAM.
//    out_valid rises on the next clock edge (1-cycle latency from the rise).
//  - STREAM: out_valid=1; out_data = shadow[sel][idx]. A handshake is out_valid & out_ready.
//    On a handshake, idx increments. When idx wraps 15->0, sel increments.
//    A handshake on sel=2, idx=15 (out_last=1) returns the block to IDLE; out_valid=0 on the next cycle.
//  - Backpressure: while out_valid & ~out_ready, out_data/out_sel/out_idx/out_last stay stable.
//    out_valid never drops without a handshake.
//  - Overrun: a rise while in STREAM sets overrun=1. The new data is ignored and the shadow
//    registers stay untouched.
//    A rise in the same cycle as the final handshake also counts as overrun (state is still STREAM).
//    clr_overrun clears the flag next cycle. If clr_overrun and a new overrun coincide, set wins.
//  - en_out_svd held high across several cycles produces exactly one capture.
//  - Throughput: 48 cycles minimum per result set with out_ready tied high.
// CONFIGURATION
//  SVD_UNLOAD_PARITY_EN defined: adds output out_parity (1 bit) = ^out_data (even parity).
//    It is registered alongside out_data and held under backpressure; reset value 0.
//  Not defined: port out_parity absent; no parity logic.
// STRUCTURE
//  - Shared package svd_pkg:
//      MAT_A=2'd0, MAT_U=2'd1, MAT_V=2'd2
//      state typedef {ST_IDLE, ST_STREAM}
//      ELEM_IDX_W=4
//  - One sub-module svd_elem_select: combinational mux of the 3x16 shadow array by (sel, idx)
//    to out_data. The top holds the FSM, counters, shadow registers and the overrun flag.
// TESTING
//  1 A[k]=k+1, U[k]=0x100+k, V[k]=0x200+k, out_ready=1, pulse en_out_svd
//    -> 48 beats in order, first beat 1 cycle after the rise, out_last only on V[15]=0x20F, busy drops after.
//  2 Same data, out_ready toggled 1/0 each cycle
//    -> identical 48-beat sequence; fields stable during stalls; 95 cycles from first valid to last handshake.
//  3 Pulse en_out_svd again at beat 10 with different data
//    -> overrun=1; beats 10..47 still carry the first data set.
//    -> Then clr_overrun -> overrun=0 next cycle.
//  4 Hold en_out_svd high for 100 cycles, out_ready=1 -> exactly 48 beats, no second capture, overrun=0.
//  5 Assert rst_n=0 at beat 20, release, then pulse en_out_svd with new data
//    -> outputs 0 during reset; the new stream starts at A[0] with the new data.
//  6 With SVD_UNLOAD_PARITY_EN and A[0]=0x000007 -> out_parity=1 on beat 0.

Source files
------------

// File: rtl/svd_pkg.sv
// Shared types and constants for the SVD result unloader slice.
// Matrix tags, FSM state encoding and the even-parity helper.
package svd_pkg;

  localparam logic [1:0] MAT_A = 2'd0;
  localparam logic [1:0] MAT_U = 2'd1;
  localparam logic [1:0] MAT_V = 2'd2;

  localparam int ELEM_IDX_W = 4;
  localparam int PAR_MAX_W  = 64;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] i_d);
    return ^i_d;
  endfunction

endpackage

// File: rtl/svd_elem_select.sv
// Combinational element mux: picks one element of the A/U/V shadow
// array by matrix tag and element index.
module svd_elem_select
  import svd_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_ELEM   = 16
) (
  input  logic [NUM_ELEM*DATA_WIDTH-1:0] i_mat_a,
  input  logic [NUM_ELEM*DATA_WIDTH-1:0] i_mat_u,
  input  logic [NUM_ELEM*DATA_WIDTH-1:0] i_mat_v,
  input  logic [1:0]                     i_sel,
  input  logic [ELEM_IDX_W-1:0]          i_idx,
  output logic [DATA_WIDTH-1:0]          o_data
);

  // element lookup by (sel, idx); tag 3 is never used and reads as zero
  always_comb begin
    o_data = '0;
    case (i_sel)
      MAT_A:   o_data = i_mat_a[i_idx*DATA_WIDTH +: DATA_WIDTH];
      MAT_U:   o_data = i_mat_u[i_idx*DATA_WIDTH +: DATA_WIDTH];
      MAT_V:   o_data = i_mat_v[i_idx*DATA_WIDTH +: DATA_WIDTH];
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/svd_result_unloader.sv
// Captures the A/U/V result words on a rising en_out_svd and streams them
// element by element over valid/ready. Optional feature: SVD_UNLOAD_PARITY_EN.
module svd_result_unloader
  import svd_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int NUM_ELEM    = 16,
  parameter int DATA_CORDIC = NUM_ELEM*DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_out_svd,
  input  logic [DATA_CORDIC-1:0] data_in_A,
  input  logic [DATA_CORDIC-1:0] data_in_U,
  input  logic [DATA_CORDIC-1:0] data_in_V,
  input  logic                   out_ready,
  input  logic                   clr_overrun,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [1:0]             out_sel,
  output logic [ELEM_IDX_W-1:0]  out_idx,
  output logic                   out_last,
  output logic                   busy,
`ifdef SVD_UNLOAD_PARITY_EN
  output logic                   out_parity,
`endif
  output logic                   overrun
);

  state_t                  r_state;
  logic                    r_en_q;
  logic [DATA_CORDIC-1:0]  r_shadow_a;
  logic [DATA_CORDIC-1:0]  r_shadow_u;
  logic [DATA_CORDIC-1:0]  r_shadow_v;
  logic [1:0]              r_sel;
  logic [ELEM_IDX_W-1:0]   r_idx;
  logic                    r_valid;
  logic                    r_last;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_overrun;

  logic                    w_rise;
  logic                    w_hs;
  logic [1:0]              w_sel_nxt;
  logic [ELEM_IDX_W-1:0]   w_idx_nxt;
  logic                    w_last_nxt;
  logic [DATA_WIDTH-1:0]   w_mux_data;
  logic [DATA_WIDTH-1:0]   w_data_nxt;

  assign w_rise     = en_out_svd & ~r_en_q;
  assign w_hs       = r_valid & out_ready;
  assign w_idx_nxt  = r_idx + 4'd1;
  assign w_sel_nxt  = (r_idx == 4'd15) ? (r_sel + 2'd1) : r_sel;
  assign w_last_nxt = (w_sel_nxt == MAT_V) && (w_idx_nxt == 4'd15);

  // the mux looks one element ahead so out_data can stay a plain register
  svd_elem_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_ELEM   (NUM_ELEM)
  ) u_elem_select (
    .i_mat_a (r_shadow_a),
    .i_mat_u (r_shadow_u),
    .i_mat_v (r_shadow_v),
    .i_sel   (w_sel_nxt),
    .i_idx   (w_idx_nxt),
    .o_data  (w_mux_data)
  );

  // next output element: A[0] straight from the input on capture, else lookahead
  always_comb begin
    w_data_nxt = r_data;
    if ((r_state == ST_IDLE) && w_rise) begin
      w_data_nxt = data_in_A[DATA_WIDTH-1:0];
    end else if ((r_state == ST_STREAM) && w_hs) begin
      w_data_nxt = r_last ? '0 : w_mux_data;
    end else begin
      w_data_nxt = r_data;
    end
  end

  // stream FSM, shadow capture, index counters and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_en_q     <= 1'b0;
      r_shadow_a <= '0;
      r_shadow_u <= '0;
      r_shadow_v <= '0;
      r_sel      <= 2'd0;
      r_idx      <= 4'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_data     <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_en_q <= en_out_svd;
      r_data <= w_data_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_shadow_a <= data_in_A;
            r_shadow_u <= data_in_U;
            r_shadow_v <= data_in_V;
            r_sel      <= MAT_A;
            r_idx      <= 4'd0;
            r_valid    <= 1'b1;
            r_last     <= 1'b0;
            r_state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_hs && r_last) begin
            r_sel   <= 2'd0;
            r_idx   <= 4'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_hs) begin
            r_sel  <= w_sel_nxt;
            r_idx  <= w_idx_nxt;
            r_last <= w_last_nxt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
      // a new result during STREAM (including the final beat) is dropped and flagged
      if (w_rise && (r_state == ST_STREAM)) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef SVD_UNLOAD_PARITY_EN
  logic r_parity;

  // parity tracks out_data so it holds under backpressure as well
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= even_parity(PAR_MAX_W'(w_data_nxt));
    end
  end

  assign out_parity = r_parity;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign busy      = (r_state == ST_STREAM);
  assign overrun   = r_overrun;

endmodule
